// File: rtl/bcd_stopwatch_counter_if.sv
// Control and display-digit bundle of the two-digit BCD stopwatch.
// The master drives the controls and reads the digits; the counter is the slave.
interface bcd_stopwatch_counter_if;
    logic       start_stop;
    logic       clr;
    logic       up_dn;
    logic       load;
    logic [3:0] load_ones;
    logic [3:0] load_tens;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       wrap;

    modport master (
        output start_stop, clr, up_dn, load, load_ones, load_tens,
        input  ones, tens, running, wrap
    );

    modport slave (
        input  start_stop, clr, up_dn, load, load_ones, load_tens,
        output ones, tens, running, wrap
    );
endinterface

// File: rtl/bcd_stopwatch_counter.sv
// Two-digit BCD up/down stopwatch with a run/hold toggle button, clear and parallel load.
// All digit/status outputs come straight from flops.
module bcd_stopwatch_counter #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_stopwatch_counter_if.slave  bus,
    output logic [1:0]              dbg_state
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            ss_q;
    logic [PW-1:0]   presc, presc_n;
    logic [3:0]      ones_r, ones_n;
    logic [3:0]      tens_r, tens_n;
    logic            wrap_r, wrap_n;
    logic            running_r;
    logic            ss_edge;
    logic            tick;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign ss_edge = bus.start_stop & ~ss_q;
    assign tick    = (state == RUN) && (presc == PRESC_LAST);

    // One decision per cycle: clr > load (outside RUN) > button edge > tick.
    always_comb begin
        state_n = state;
        presc_n = presc;
        ones_n  = ones_r;
        tens_n  = tens_r;
        wrap_n  = 1'b0;
        if (bus.clr) begin
            state_n = IDLE;
            presc_n = '0;
            ones_n  = 4'd0;
            tens_n  = 4'd0;
        end else if (bus.load && (state != RUN)) begin
            state_n = HOLD;
            presc_n = '0;
            ones_n  = clamp9(bus.load_ones);
            tens_n  = clamp9(bus.load_tens);
        end else if (ss_edge) begin
            presc_n = '0;
            case (state)
                IDLE, HOLD: state_n = RUN;
                RUN:        state_n = HOLD;
                default:    state_n = IDLE;
            endcase
        end else if (state == RUN) begin
            if (tick) begin
                presc_n = '0;
                if (bus.up_dn) begin
                    if (ones_r < 4'd9) begin
                        ones_n = ones_r + 4'd1;
                    end else begin
                        ones_n = 4'd0;
                        if (tens_r < 4'd9) begin
                            tens_n = tens_r + 4'd1;
                        end else begin
                            tens_n = 4'd0;
                            wrap_n = 1'b1;
                        end
                    end
                end else begin
                    if (ones_r > 4'd0) begin
                        ones_n = ones_r - 4'd1;
                    end else begin
                        ones_n = 4'd9;
                        if (tens_r > 4'd0) begin
                            tens_n = tens_r - 4'd1;
                        end else begin
                            tens_n = 4'd9;
                            wrap_n = 1'b1;
                        end
                    end
                end
            end else begin
                presc_n = presc + PW'(1);
            end
        end else begin
            presc_n = '0;
        end
    end

    // ss_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ss_q      <= 1'b1;
            presc     <= '0;
            ones_r    <= 4'd0;
            tens_r    <= 4'd0;
            wrap_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state     <= state_n;
            ss_q      <= bus.start_stop;
            presc     <= presc_n;
            ones_r    <= ones_n;
            tens_r    <= tens_n;
            wrap_r    <= wrap_n;
            running_r <= (state_n == RUN);
        end
    end

    assign bus.ones    = ones_r;
    assign bus.tens    = tens_r;
    assign bus.wrap    = wrap_r;
    assign bus.running = running_r;
    assign dbg_state   = state;
endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Bench for bcd_stopwatch_counter: directed vector table, corner-case sequences and
// randomized traffic, all compared against an integer-count reference model.
module tb_bcd_stopwatch_counter;
    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    bcd_stopwatch_counter_if bus ();

    bcd_stopwatch_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: count held as a plain integer 0..99, mode 0=idle 1=run 2=hold.
    int m_count   = 0;
    int m_mode    = 0;
    int m_age     = 0;
    bit m_wrap    = 1'b0;
    bit m_ss_prev = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       r, ss, c, ud, ld;
        logic [3:0] lo, lt;
        logic [3:0] e_tens, e_ones;
        logic       e_run, e_wrap;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [9:0] observed();
        return {bus.tens, bus.ones, bus.running, bus.wrap};
    endfunction

    function automatic logic [9:0] modeled();
        return {4'(m_count / 10), 4'(m_count % 10), (m_mode == 1), m_wrap};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got tens=%0d ones=%0d running=%0b wrap=%0b, want tens=%0d ones=%0d running=%0b wrap=%0b",
                     name, $time, act[9:6], act[5:2], act[1], act[0], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic model_step();
        int lo;
        int lt;
        bit edge_seen;
        if (rst) begin
            m_count = 0; m_mode = 0; m_age = 0; m_wrap = 1'b0; m_ss_prev = 1'b1;
            return;
        end
        edge_seen = bus.start_stop && !m_ss_prev;
        m_ss_prev = bus.start_stop;
        m_wrap    = 1'b0;
        if (bus.clr) begin
            m_count = 0; m_mode = 0; m_age = 0;
        end else if (bus.load && m_mode != 1) begin
            lo = (int'(bus.load_ones) > 9) ? 9 : int'(bus.load_ones);
            lt = (int'(bus.load_tens) > 9) ? 9 : int'(bus.load_tens);
            m_count = lt * 10 + lo; m_mode = 2; m_age = 0;
        end else if (edge_seen) begin
            m_mode = (m_mode == 1) ? 2 : 1;
            m_age  = 0;
        end else if (m_mode == 1) begin
            m_age++;
            if (m_age == TICK_DIV) begin
                m_age = 0;
                if (bus.up_dn) begin
                    m_wrap  = (m_count == 99);
                    m_count = (m_count + 1) % 100;
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count + 99) % 100;
                end
            end
        end
    endtask

    task automatic set_in(input logic r, input logic ss, input logic c, input logic ud,
                          input logic ld, input logic [3:0] lo, input logic [3:0] lt);
        rst = r; bus.start_stop = ss; bus.clr = c; bus.up_dn = ud;
        bus.load = ld; bus.load_ones = lo; bus.load_tens = lt;
    endtask

    task automatic cycle(input string name);
        model_step();
        @(posedge clk);
        #1;
        check(name, observed(), modeled());
    endtask

    task automatic run_cycles(input int n, input string name);
        for (int k = 0; k < n; k++) cycle(name);
    endtask

    initial begin
        set_in(1, 0, 0, 1, 0, 4'd0, 4'd0);

        //              r  ss c  ud ld lo     lt     tens  ones  run  wrap
        tbl.push_back('{1, 1, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b0, 1'b0});
        tbl.push_back('{1, 1, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b0, 1'b0});
        tbl.push_back('{0, 1, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b0, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b0, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 1, 4'hC, 4'hF, 4'd9, 4'd9, 1'b0, 1'b0});
        tbl.push_back('{0, 1, 1, 1, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b0, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b0, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 1, 4'h8, 4'h9, 4'd9, 4'd8, 1'b0, 1'b0});
        tbl.push_back('{0, 1, 0, 1, 0, 4'h0, 4'h0, 4'd9, 4'd8, 1'b1, 1'b0});
        tbl.push_back('{0, 1, 0, 1, 0, 4'h0, 4'h0, 4'd9, 4'd8, 1'b1, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 1, 4'h3, 4'h3, 4'd9, 4'd8, 1'b1, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd9, 4'd8, 1'b1, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd9, 4'd9, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd9, 4'd9, 1'b1, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b1, 1'b1});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b1, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd1, 1'b1, 1'b0});
        tbl.push_back('{0, 1, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd1, 1'b0, 1'b0});
        tbl.push_back('{0, 0, 0, 1, 0, 4'h0, 4'h0, 4'd0, 4'd1, 1'b0, 1'b0});
        tbl.push_back('{0, 1, 0, 0, 0, 4'h0, 4'h0, 4'd0, 4'd1, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{0, 0, 0, 0, 0, 4'h0, 4'h0, 4'd0, 4'd1, 1'b1, 1'b0});
        tbl.push_back('{0, 0, 0, 0, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b1, 1'b0});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{0, 0, 0, 0, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b1, 1'b0});
        tbl.push_back('{0, 0, 0, 0, 0, 4'h0, 4'h0, 4'd9, 4'd9, 1'b1, 1'b1});
        tbl.push_back('{1, 0, 0, 0, 0, 4'h0, 4'h0, 4'd0, 4'd0, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            set_in(tbl[i].r, tbl[i].ss, tbl[i].c, tbl[i].ud, tbl[i].ld, tbl[i].lo, tbl[i].lt);
            cycle($sformatf("vec%0d_model", i));
            check($sformatf("vec%0d", i), observed(),
                  {tbl[i].e_tens, tbl[i].e_ones, tbl[i].e_run, tbl[i].e_wrap});
        end

        // Reset with nothing pressed, then 20 idle cycles.
        set_in(1, 0, 0, 1, 0, 4'd0, 4'd0); run_cycles(2, "idle_rst");
        set_in(0, 0, 0, 1, 0, 4'd0, 4'd0);
        for (int k = 0; k < 20; k++) begin
            cycle("idle_model");
            check("idle", observed(), 10'd0);
        end

        // Down count from 10 through 00 and the borrow to 99.
        set_in(0, 0, 1, 0, 0, 4'd0, 4'd0); cycle("dn_clr");
        set_in(0, 0, 0, 0, 1, 4'd0, 4'd1); cycle("dn_load");
        check("dn_load10", observed(), {4'd1, 4'd0, 1'b0, 1'b0});
        set_in(0, 1, 0, 0, 0, 4'd0, 4'd0); cycle("dn_start");
        set_in(0, 0, 0, 0, 0, 4'd0, 4'd0);
        for (int s = 1; s <= 11; s++) begin
            int exp_v;
            run_cycles(TICK_DIV, "dn_run");
            exp_v = (10 - s + 100) % 100;
            check("dn_step", observed(), {4'(exp_v / 10), 4'(exp_v % 10), 1'b1, (s == 11)});
        end
        cycle("dn_wrap_clear");

        // Pause and resume: the resume step needs a full tick period.
        set_in(0, 0, 1, 1, 0, 4'd0, 4'd0); cycle("pr_clr");
        set_in(0, 1, 0, 1, 0, 4'd0, 4'd0); cycle("pr_start");
        set_in(0, 0, 0, 1, 0, 4'd0, 4'd0); run_cycles(TICK_DIV, "pr_run");
        check("pr_first", observed(), {4'd0, 4'd1, 1'b1, 1'b0});
        cycle("pr_run2");
        set_in(0, 1, 0, 1, 0, 4'd0, 4'd0); cycle("pr_stop");
        check("pr_stopped", observed(), {4'd0, 4'd1, 1'b0, 1'b0});
        set_in(0, 0, 0, 1, 0, 4'd0, 4'd0);
        for (int k = 0; k < 10; k++) begin
            cycle("pr_hold_model");
            check("pr_held", observed(), {4'd0, 4'd1, 1'b0, 1'b0});
        end
        set_in(0, 1, 0, 1, 0, 4'd0, 4'd0); cycle("pr_restart");
        set_in(0, 0, 0, 1, 0, 4'd0, 4'd0); run_cycles(TICK_DIV - 1, "pr_resume");
        check("pr_not_yet", observed(), {4'd0, 4'd1, 1'b1, 1'b0});
        cycle("pr_resume_tick");
        check("pr_step02", observed(), {4'd0, 4'd2, 1'b1, 1'b0});

        // Reset landing on the 99->00 tick cycle, then a fresh full period.
        set_in(0, 0, 1, 1, 0, 4'd0, 4'd0); cycle("rw_clr");
        set_in(0, 0, 0, 1, 1, 4'd9, 4'd9); cycle("rw_load");
        set_in(0, 1, 0, 1, 0, 4'd0, 4'd0); cycle("rw_start");
        set_in(0, 0, 0, 1, 0, 4'd0, 4'd0); run_cycles(TICK_DIV - 1, "rw_run");
        set_in(1, 0, 0, 1, 0, 4'd0, 4'd0); cycle("rw_rst_model");
        check("rw_rst", observed(), 10'd0);
        set_in(0, 0, 0, 1, 0, 4'd0, 4'd0); cycle("rw_after");
        set_in(0, 1, 0, 1, 0, 4'd0, 4'd0); cycle("rw_start2");
        set_in(0, 0, 0, 1, 0, 4'd0, 4'd0); run_cycles(TICK_DIV, "rw_run2");
        check("rw_presc", observed(), {4'd0, 4'd1, 1'b1, 1'b0});

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            logic ss_next;
            ss_next = ($urandom_range(0, 9) == 0) ? ~bus.start_stop : bus.start_stop;
            set_in(($urandom_range(0, 299) == 0), ss_next, ($urandom_range(0, 79) == 0),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_stopwatch_counter.md
# bcd_stopwatch_counter

Two-digit BCD stopwatch/counter that produces the `ones` and `tens` digits consumed by the multiplexed 7-segment display driver. It divides the system clock into a count tick, steps a 00–99 BCD value up or down, and is controlled by a start/stop button, a clear input and a parallel load. All outputs are registered, so the display stage can sample them on any clock.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per count step (1 Hz at 100 MHz). Legal range is ≥ 2. The prescaler width is ceil(log2(TICK_DIV)).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_stop`  in  1  debounced button level. Its rising edge toggles run/hold.
- `clr`  in  1  synchronous clear to 00 / IDLE. Level-sensitive.
- `up_dn`  in  1  1 = count up, 0 = count down. Sampled on tick cycles only.
- `load`  in  1  parallel-load strobe.
- `load_ones`  in  4  BCD value loaded into `ones`.
- `load_tens`  in  4  BCD value loaded into `tens`.
- `ones`  out  4  BCD units digit, 0–9.
- `tens`  out  4  BCD tens digit, 0–9.
- `running`  out  1  high while in RUN.
- `wrap`  out  1  one-cycle pulse when the count wraps 99→00 (up) or 00→99 (down).

## Operation
- Reset values: `ones`=0, `tens`=0, `running`=0, `wrap`=0, state=IDLE, prescaler=0.
- Edge-detect register `ss_q` resets to 1, so a button held through reset does not start the count. Definition: `ss_edge` = `start_stop` & ~`ss_q`.
- States:
  - IDLE: count is 00, stopped.
  - RUN: counting.
  - HOLD: stopped, count retained.
- Transitions on `ss_edge`:
  - IDLE→RUN
  - RUN→HOLD
  - HOLD→RUN
- `clr`: any state→IDLE, digits←00.
- `load`:
  - In IDLE or HOLD: digits←load values, state→HOLD.
  - In RUN: ignored.
  - Clamping: each load digit >9 is clamped to 9, independently per digit.
- Per-cycle priority: `rst` > `clr` > `load` > `ss_edge` > tick.
  - A lower-priority event in the same cycle is dropped, not deferred.
  - Example: `clr` together with `ss_edge` ends in IDLE.
- Prescaler:
  - Increments only in RUN.
  - Forced to 0 in IDLE/HOLD and on `clr`/`load`.
  - Pausing therefore restarts a full tick period.
  - tick = RUN && prescaler == TICK_DIV-1. The prescaler wraps to 0 on tick.
- Step, up:
  - ones<9: ones+1.
  - Otherwise ones←0 and tens+1.
  - At 99: next value is 00 with `wrap`.
- Step, down:
  - ones>0: ones−1.
  - Otherwise ones←9 and tens−1.
  - At 00: next value is 99 with `wrap`.
- Digits never leave 0–9. No binary intermediate is used; each digit is stepped directly.

## Timing
- `ss_edge` in cycle N: state and `running` change at the end of cycle N, visible in N+1.
- First tick after entering RUN is exactly TICK_DIV cycles later. Following ticks are every TICK_DIV cycles.
- Tick in cycle N: new digits and `wrap` (if any) are visible in cycle N+1. `wrap` is high for exactly that one cycle.
- `clr`/`load` in cycle N: digits and state are updated in N+1. `wrap` is 0 in N+1.
- `up_dn` change mid-period: takes effect on the next tick. No glitch on the digits.
- `rst` mid-count: all outputs return to reset values in the next cycle, regardless of other inputs.
- A `start_stop` held high produces a single edge. Release-then-press is required for the next toggle.

## Test plan
- Reset/idle, TICK_DIV=4:
  - Stimulus: `rst` high 2 cycles, then idle 20 cycles with `start_stop`=0.
  - Required: `ones`=`tens`=0, `running`=0 throughout.
  - Stimulus: `start_stop` held 1 across reset.
  - Required: still no start.
- Up count and wrap:
  - Stimulus: load 9/8 (98), press start, `up_dn`=1.
  - Required: 99 after 4 cycles, then 00 with `wrap`=1 for one cycle after 8 cycles, then 01 after 12 cycles.
- Down count and borrow:
  - Stimulus: load 1/0 (10), start, `up_dn`=0.
  - Required: sequence 09, 08, … 00, then 99 with `wrap` pulse, one step per 4 cycles.
- Pause/resume:
  - Stimulus: start from 00, stop 2 cycles after the first step (count 01), hold 10 cycles, restart.
  - Required: count stays 01 while held, and the next step to 02 comes exactly 4 cycles after the restart edge.
- Priority/clamp:
  - Stimulus: `clr`+`ss_edge` in the same cycle.
  - Required: IDLE, 00, `running`=0.
  - Stimulus: `load` during RUN.
  - Required: ignored.
  - Stimulus: load `load_ones`=4'hC, `load_tens`=4'hF in HOLD.
  - Required: digits 9/9.
- Mid-operation reset:
  - Stimulus: `rst` asserted during a wrap cycle at 99.
  - Required: the next cycle shows 00, `wrap`=0, `running`=0, and the prescaler restarts from 0.
